grid_cell_sched: RTL
====================

# grid_cell_sched

Arbitrating write scheduler for the 90×120 cell grid. It accepts linear cell indices from two requesters and converts each to a (row, col) position with a fixed-latency sequential divider, so no `/` or `%` operators are used. It then issues a single-cycle write to the grid store. It also runs a full-grid clear sweep on command, and sits between game/control logic and the grid storage feeding the display path.

## Interface
- `ROWS`, default 90: grid rows.
- `COLS`, default 120: grid columns.
- `IDX_W`, default 16: index width.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid[1:0]`  in  2  per-requester request valid.
- `req_ready[1:0]`  out  2  per-requester accept.
- `req_idx0`, `req_idx1`  in  IDX_W each  linear cell index, row-major: idx = row*COLS + col.
- `req_val0`, `req_val1`  in  1 each  bit to write.
- `clear_req`  in  1  single-cycle pulse that requests a full-grid clear.
- `clear_busy`  out  1  high while a clear is pending or sweeping.
- `wr_en`  out  1  single-cycle grid write strobe.
- `wr_row`  out  ROW_W  target row.
- `wr_col`  out  COL_W  target column.
- `wr_val`  out  1  data bit.
- `err`  out  1  single-cycle pulse when an accepted index is ≥ ROWS*COLS.

## Operation
- States:
  - IDLE: waits for work.
  - DIV: runs ROW_W cycles of division.
  - WRITE: 1 cycle, issues the write.
  - CLEAR: sweeps the grid.
- IDLE transitions:
  - A pending clear goes to CLEAR. Clear beats requests.
  - Otherwise a valid request is granted and the block goes to DIV.
- `req_ready[i]` is high only in IDLE, with no clear pending, for the requester the arbiter grants that cycle. At most one ready bit is high.
- Arbitration is round-robin on a 1-bit last-grant pointer.
  - With both requesters valid, the requester not granted last wins.
  - Reset sets the pointer so that req0 wins first.
- Accepting a request latches its idx and val.
- Out-of-range index (idx ≥ ROWS*COLS):
  - Pulses `err` the next cycle.
  - Returns to IDLE with no write.
  - Does not enter DIV.
- DIV is a restoring division, one step per cycle for k = ROW_W−1 down to 0:
  - If rem ≥ COLS<<k, then rem −= COLS<<k and q[k] = 1.
  - Result: row = q, col = rem.
- WRITE drives `wr_en`=1 with the latched row, col and val, then returns to IDLE.
- `clear_req` arriving in any non-CLEAR state is latched and sets `clear_busy` immediately. Any in-flight request finishes its write first.
- CLEAR behaviour:
  - Row/col counters start at (0,0).
  - One write per cycle with `wr_val`=0. Col increments and wraps at COLS−1, then row increments.
  - After writing (ROWS−1, COLS−1) the block returns to IDLE and `clear_busy` drops.
  - A `clear_req` during CLEAR is ignored.
- `wr_row`, `wr_col` and `wr_val` hold their last values when `wr_en`=0.

## Timing
- Reset values: `wr_en`, `wr_row`, `wr_col`, `wr_val`, `err`, `req_ready`, `clear_busy` all 0. State is IDLE. Round-robin pointer favours req0.
- Request accepted at edge T:
  - DIV occupies cycles T+1 … T+ROW_W (7 at defaults).
  - `wr_en` is high in cycle T+ROW_W+1.
  - `req_ready` can next be high at T+ROW_W+2.
- Throughput: one request per ROW_W+2 cycles.
- Error path: `err` is high in cycle T+1, and the block is back in IDLE at T+2.
- Clear latency:
  - `clear_req` sampled in IDLE at edge T gives the first clear write in T+1.
  - The sweep lasts exactly ROWS*COLS cycles (10800).
  - `clear_busy` falls in the cycle after the last write.
- `clear_req` and `req_valid` in the same IDLE cycle: clear wins, and the request stays pending. `req_ready` is 0 that cycle.
- `rst` has priority over everything. Mid-DIV or mid-CLEAR it aborts all work, drops any latched clear, and produces no partial write.

## Structure
- Package `grid_pkg` holds:
  - ROWS, COLS.
  - ROW_W = $clog2(ROWS), COL_W = $clog2(COLS).
  - CELLS = ROWS*COLS.
  - The state enum `sched_state_t`.
- Sub-module `grid_idx_div` is the sequential restoring divider:
  - Inputs: start, idx.
  - Outputs: done, row, col.
  - Fixed latency of ROW_W cycles.
- Arbitration, clear counters and the FSM stay in `grid_cell_sched`.

## Test plan
- req0 only, idx=245, val=1, accepted at T → `wr_en` at T+8 with row=2, col=5, val=1; `err`=0.
- req1 idx=10799 → row=89, col=119. Then req0 idx=10800 → `err` pulse at T+1 and no `wr_en`.
- Both valid (idx 0 and 121) held continuously → grants in order req0, req1, req0. Writes go to (0,0), (1,1), (0,0) at 9-cycle spacing.
- `clear_req` in IDLE → 10800 consecutive `wr_en` pulses with `wr_val`=0. First write is (0,0), last is (89,119). `clear_busy` falls the next cycle. `req_ready`=0 throughout.
- `clear_req` in DIV of a request with idx=361 → write to (3,1) completes first, then the clear sweep starts the following cycle.
- `rst` asserted during cycle 4 of DIV → all outputs 0 the next cycle and no write issued. A new req0 is accepted after `rst` deasserts.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared geometry and state encoding for the cell-grid write scheduler.
package grid_pkg;
    localparam int ROWS  = 90;
    localparam int COLS  = 120;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_WRITE,
        S_CLEAR
    } sched_state_t;
endpackage

// File: rtl/grid_idx_div.sv
// Sequential restoring divider: linear cell index -> (row, col), one quotient bit per cycle.
module grid_idx_div #(
    parameter int ROWS  = 90,
    parameter int COLS  = 120,
    parameter int IDX_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [IDX_W-1:0]         idx,
    output logic                     done,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic [$clog2(COLS)-1:0]  col
);
    localparam int RB = $clog2(ROWS);
    localparam int CB = $clog2(COLS);
    localparam int W  = IDX_W + RB;

    logic [W-1:0]  rem;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  divisor;
    logic [RB-1:0] q;
    logic [RB-1:0] q_nxt;
    logic [RB-1:0] k;
    logic          busy;
    logic          fits;

    // The final step is exposed combinationally so the caller can register
    // the result on the same edge that completes the division.
    always_comb begin
        divisor = W'(COLS) << k;
        fits    = (rem >= divisor);
        rem_nxt = fits ? (rem - divisor) : rem;
        q_nxt   = q;
        if (fits) q_nxt[k] = 1'b1;
        done    = busy && (k == '0);
        row     = q_nxt;
        col     = rem_nxt[CB-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (start) begin
            rem  <= W'(idx);
            q    <= '0;
            k    <= RB'(RB - 1);
            busy <= 1'b1;
        end else if (busy) begin
            rem <= rem_nxt;
            q   <= q_nxt;
            k   <= k - 1'b1;
            if (k == '0) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/grid_cell_sched.sv
// Round-robin write scheduler for the cell grid: converts linear indices via
// the divider, issues single-cycle writes, and runs full-grid clear sweeps.
module grid_cell_sched #(
    parameter int ROWS  = 90,
    parameter int COLS  = 120,
    parameter int IDX_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [IDX_W-1:0]         req_idx0,
    input  logic [IDX_W-1:0]         req_idx1,
    input  logic                     req_val0,
    input  logic                     req_val1,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic                     wr_en,
    output logic [$clog2(ROWS)-1:0]  wr_row,
    output logic [$clog2(COLS)-1:0]  wr_col,
    output logic                     wr_val,
    output logic                     err
);
    import grid_pkg::*;

    localparam int ROW_BITS = $clog2(ROWS);
    localparam int COL_BITS = $clog2(COLS);
    localparam int NCELLS   = ROWS * COLS;

    sched_state_t        state;
    logic                last;
    logic                grant;
    logic                accept;
    logic                in_range;
    logic                clear_pend;
    logic                start_clear;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_val;
    logic                val_q;
    logic                div_start;
    logic                div_done;
    logic [ROW_BITS-1:0] div_row;
    logic [COL_BITS-1:0] div_col;

    always_comb begin
        grant = (req_valid == 2'b11) ? ~last : req_valid[1];
        sel_idx = grant ? req_idx1 : req_idx0;
        sel_val = grant ? req_val1 : req_val0;
        in_range = ({1'b0, sel_idx} < (IDX_W + 1)'(NCELLS));
        // clear_busy doubles as the pending flag while outside the sweep
        clear_pend = clear_busy && (state != S_CLEAR);
        start_clear = clear_req || clear_pend;
        accept = !rst && (state == S_IDLE) && !start_clear && (req_valid != 2'b00);
        div_start = accept && in_range;
        req_ready = 2'b00;
        if (accept) req_ready[grant] = 1'b1;
    end

    grid_idx_div #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (IDX_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .idx   (sel_idx),
        .done  (div_done),
        .row   (div_row),
        .col   (div_col)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last       <= 1'b1;
            wr_en      <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_val     <= 1'b0;
            err        <= 1'b0;
            clear_busy <= 1'b0;
            val_q      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            err   <= 1'b0;
            if (clear_req && state != S_CLEAR) clear_busy <= 1'b1;
            case (state)
                S_IDLE, S_WRITE: begin
                    if (start_clear) begin
                        state  <= S_CLEAR;
                        wr_en  <= 1'b1;
                        wr_row <= '0;
                        wr_col <= '0;
                        wr_val <= 1'b0;
                    end else if (accept) begin
                        last  <= grant;
                        val_q <= sel_val;
                        // out-of-range requests skip the divider and reuse WRITE
                        // as a one-cycle dead slot with no strobe
                        if (in_range) begin
                            state <= S_DIV;
                        end else begin
                            err   <= 1'b1;
                            state <= S_WRITE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        state  <= S_WRITE;
                        wr_en  <= 1'b1;
                        wr_row <= div_row;
                        wr_col <= div_col;
                        wr_val <= val_q;
                    end
                end
                S_CLEAR: begin
                    if (wr_row == ROW_BITS'(ROWS - 1) && wr_col == COL_BITS'(COLS - 1)) begin
                        state      <= S_IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        wr_en <= 1'b1;
                        if (wr_col == COL_BITS'(COLS - 1)) begin
                            wr_col <= '0;
                            wr_row <= wr_row + 1'b1;
                        end else begin
                            wr_col <= wr_col + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
